// File: rtl/bound_arbiter_pkg.sv
// Shared flit-format macros and arbiter types for the bound-link packet arbiter.
// The flit type field sits in the two top bits of every flit.
`ifndef BOUND_ARBITER_MACROS
`define BOUND_ARBITER_MACROS
`define DW            32
`define HEAD          2'b01
`define BODY          2'b00
`define TAIL          2'b10
`define BARB_N_IN     4
`define BARB_N_IN_LOG 2
`endif

package bound_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int FT_W = 2;

    function automatic logic [FT_W-1:0] flit_type(input logic [`DW-1:0] flit);
        return flit[`DW-1:`DW-FT_W];
    endfunction

endpackage

// File: rtl/bound_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// The request vector is doubled and shifted so the search always starts at bit 0.
module rr_arbiter #(
    parameter int N_IN     = 4,
    parameter int N_IN_LOG = 2
) (
    input  logic [N_IN-1:0]     req,
    input  logic [N_IN_LOG-1:0] ptr,
    output logic [N_IN-1:0]     gnt,
    output logic [N_IN_LOG-1:0] idx,
    output logic                any
);

    localparam int SUM_W = N_IN_LOG + 1;

    logic [2*N_IN-1:0]   dbl_s;
    logic [N_IN-1:0]     rot_s;
    logic [N_IN_LOG-1:0] off_s;
    logic                found_s;
    logic [SUM_W-1:0]    sum_s;
    logic [SUM_W-1:0]    sum_wrap_s;

    // rotate requests, find first set bit, map offset back to absolute index
    always_comb begin
        dbl_s   = {req, req};
        rot_s   = N_IN'(dbl_s >> ptr);
        off_s   = {N_IN_LOG{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (!found_s && rot_s[i]) begin
                off_s   = N_IN_LOG'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        sum_s      = {1'b0, ptr} + {1'b0, off_s};
        sum_wrap_s = (sum_s >= SUM_W'(N_IN)) ? (sum_s - SUM_W'(N_IN)) : sum_s;
        idx        = sum_wrap_s[N_IN_LOG-1:0];
        any        = |req;
        gnt        = {N_IN{1'b0}};
        gnt[idx]   = any;
    end

endmodule

// File: rtl/bound_arbiter.sv
// Wormhole arbiter merging N_IN boundary outputs into one bound-link input.
// One packet holds the grant from HEAD to TAIL; flits leave through one register stage.
module bound_arbiter
    import bound_arbiter_pkg::*;
#(
    parameter int N_IN     = `BARB_N_IN,
    parameter int N_IN_LOG = `BARB_N_IN_LOG,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_IN*`DW-1:0]  in_data_i,
    input  logic [N_IN-1:0]      in_valid_i,
    output logic [N_IN-1:0]      in_ready_o,
    output logic [`DW-1:0]       out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 err_o,
    output logic [CNT_W-1:0]     pkt_cnt_o
);

    arb_state_t          state_r, state_nxt_s;
    logic [N_IN_LOG-1:0] grant_r, grant_nxt_s;
    logic [N_IN_LOG-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic                out_valid_r;
    logic [`DW-1:0]      out_data_r;
    logic                err_r;
    logic [CNT_W-1:0]    pkt_cnt_r;

    logic [`DW-1:0]      flit_s [N_IN];
    logic [N_IN-1:0]     head_req_s;
    logic [N_IN-1:0]     bad_req_s;
    logic [N_IN_LOG-1:0] bad_idx_s;
    logic [N_IN-1:0]     ready_s;
    logic                slot_free_s;
    logic                fwd_s;
    logic                disc_s;
    logic                tail_s;
    logic [N_IN_LOG-1:0] sel_s;
    logic [`DW-1:0]      sel_flit_s;

    logic [N_IN-1:0]     arb_gnt_s;
    logic [N_IN_LOG-1:0] arb_idx_s;
    logic                arb_any_s;

    // split inputs into flits and classify HEAD candidates versus stray flits
    always_comb begin
        bad_idx_s = {N_IN_LOG{1'b0}};
        for (int k = 0; k < N_IN; k++) begin
            flit_s[k]     = in_data_i[k*`DW +: `DW];
            head_req_s[k] = in_valid_i[k] & (flit_type(flit_s[k]) == `HEAD);
            bad_req_s[k]  = in_valid_i[k] & (flit_type(flit_s[k]) != `HEAD);
        end
        for (int k = N_IN - 1; k >= 0; k--) begin
            bad_idx_s = bad_req_s[k] ? N_IN_LOG'(k) : bad_idx_s;
        end
    end

    rr_arbiter #(
        .N_IN     (N_IN),
        .N_IN_LOG (N_IN_LOG)
    ) u_rr (
        .req (head_req_s),
        .ptr (rr_ptr_r),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

    assign slot_free_s = ~out_valid_r | out_ready_i;

    // next-state, ready generation and accept/discard decisions
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        rr_ptr_nxt_s = rr_ptr_r;
        ready_s      = {N_IN{1'b0}};
        fwd_s        = 1'b0;
        disc_s       = 1'b0;
        tail_s       = 1'b0;
        sel_s        = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    // a blocked slot leaves the choice open for the next cycle
                    if (slot_free_s) begin
                        ready_s     = arb_gnt_s;
                        fwd_s       = 1'b1;
                        sel_s       = arb_idx_s;
                        grant_nxt_s = arb_idx_s;
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        ready_s = {N_IN{1'b0}};
                    end
                end else if (|bad_req_s) begin
                    ready_s[bad_idx_s] = 1'b1;
                    disc_s             = 1'b1;
                end else begin
                    ready_s = {N_IN{1'b0}};
                end
            end
            ST_LOCKED: begin
                ready_s[grant_r] = slot_free_s;
                fwd_s            = slot_free_s & in_valid_i[grant_r];
                if (fwd_s && (flit_type(flit_s[grant_r]) == `TAIL)) begin
                    tail_s       = 1'b1;
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = (grant_r == N_IN_LOG'(N_IN - 1)) ?
                                   {N_IN_LOG{1'b0}} : (grant_r + N_IN_LOG'(1));
                end else begin
                    tail_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        sel_flit_s = flit_s[sel_s];
    end

    // arbitration state: FSM state, latched grant, round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= ST_IDLE;
            grant_r  <= {N_IN_LOG{1'b0}};
            rr_ptr_r <= {N_IN_LOG{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // output flit register, sticky error flag and packet counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {`DW{1'b0}};
            err_r       <= 1'b0;
            pkt_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (fwd_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sel_flit_s;
            end else if (out_ready_i) begin
                out_valid_r <= 1'b0;
            end
            if (disc_s) begin
                err_r <= 1'b1;
            end
            if (tail_s) begin
                pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
            end
        end
    end

    // ready is combinational, so it is forced low while reset is held
    assign in_ready_o  = rstn ? ready_s : {N_IN{1'b0}};
    assign out_data_o  = out_data_r;
    assign out_valid_o = out_valid_r;
    assign err_o       = err_r;
    assign pkt_cnt_o   = pkt_cnt_r;

endmodule

// File: tb/tb_bound_arbiter.sv
// Self-checking bench for bound_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a packet-queue reference model.
`ifndef BOUND_ARBITER_MACROS
`define BOUND_ARBITER_MACROS
`define DW            32
`define HEAD          2'b01
`define BODY          2'b00
`define TAIL          2'b10
`define BARB_N_IN     4
`define BARB_N_IN_LOG 2
`endif

module tb_bound_arbiter;

    localparam int N  = 4;
    localparam int LG = 2;
    localparam int CW = 16;
    localparam int DW = `DW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          err;
    logic [CW-1:0] pkt_cnt;

    bound_arbiter #(.N_IN(N), .N_IN_LOG(LG), .CNT_W(CW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .err_o       (err),
        .pkt_cnt_o   (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // upstream flit queues, one per input
    logic [DW-1:0] q [N][$];
    bit            en [N];
    int            ordy_pct = 100;
    int            ordy_low = 0;
    int            seq = 0;

    // reference model state
    bit            m_locked;
    int            m_grant;
    int            m_ptr;
    bit            m_ov;
    logic [DW-1:0] m_od;
    bit            m_err;
    int            m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ft(input logic [DW-1:0] f);
        return f[DW-1:DW-2];
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_grant  = 0;
        m_ptr    = 0;
        m_ov     = 1'b0;
        m_od     = '0;
        m_err    = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic push_pkt(input int k, input int len);
        logic [DW-1:0] f;
        logic [1:0]    t;
        for (int i = 0; i < len; i++) begin
            if (i == 0) t = `HEAD;
            else if (i == len - 1) t = `TAIL;
            else t = ($urandom_range(0, 9) == 0) ? `HEAD : `BODY;
            f = $urandom;
            f[DW-1:DW-2] = t;
            f[15:0] = seq[15:0];
            seq++;
            q[k].push_back(f);
        end
    endtask

    task automatic push_stray(input int k);
        logic [DW-1:0] f;
        f = $urandom;
        f[DW-1:DW-2] = ($urandom_range(0, 1) == 0) ? `BODY : `TAIL;
        q[k].push_back(f);
    endtask

    function automatic bit busy();
        bit b = m_ov;
        for (int k = 0; k < N; k++) if (q[k].size() > 0) b = 1'b1;
        return b;
    endfunction

    // one clock: drive at negedge, check settled outputs, advance model at posedge
    task automatic step();
        logic [DW-1:0] f [N];
        logic [N-1:0]  exp_rdy;
        int            cand, fwd, disc;
        bit            slot_free;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (q[k].size() > 0 && en[k]) begin
                in_valid[k] = 1'b1;
                f[k] = q[k][0];
            end else begin
                in_valid[k] = 1'b0;
                f[k] = $urandom;
            end
            in_data[k*DW +: DW] = f[k];
        end
        if (ordy_low > 0) begin
            out_ready = 1'b0;
            ordy_low--;
        end else begin
            out_ready = ($urandom_range(1, 100) <= ordy_pct) ? 1'b1 : 1'b0;
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) chk("out_data", out_data, m_od);
        chk("err", err, m_err);
        chk("pkt_cnt", pkt_cnt, m_cnt % 65536);

        slot_free = !m_ov || out_ready;
        exp_rdy = '0;
        cand = -1;
        fwd = -1;
        disc = -1;
        if (!m_locked) begin
            for (int off = 0; off < N; off++) begin
                int k = (m_ptr + off) % N;
                if (cand < 0 && in_valid[k] && ft(f[k]) == `HEAD) cand = k;
            end
            if (cand >= 0) begin
                if (slot_free) begin
                    exp_rdy[cand] = 1'b1;
                    fwd = cand;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (disc < 0 && in_valid[k]) begin
                        disc = k;
                        exp_rdy[k] = 1'b1;
                    end
                end
            end
        end else if (slot_free) begin
            exp_rdy[m_grant] = 1'b1;
            if (in_valid[m_grant]) fwd = m_grant;
        end
        chk("in_ready", in_ready, exp_rdy);

        @(posedge clk);
        if (fwd >= 0) begin
            m_od = f[fwd];
            m_ov = 1'b1;
            void'(q[fwd].pop_front());
            if (!m_locked) begin
                m_locked = 1'b1;
                m_grant  = fwd;
            end else if (ft(m_od) == `TAIL) begin
                m_locked = 1'b0;
                m_ptr    = (m_grant + 1) % N;
                m_cnt++;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (disc >= 0) begin
            m_err = 1'b1;
            void'(q[disc].pop_front());
        end
    endtask

    task automatic drain(input string tag, input int maxc);
        int c = 0;
        while (busy() && c < maxc) begin
            step();
            c++;
        end
        chk(tag, busy(), 0);
    endtask

    initial begin
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) en[k] = 1'b1;
        model_reset();

        // reset values, with stray flits presented to prove ready stays low
        #2;
        in_valid = '1;
        for (int k = 0; k < N; k++) in_data[k*DW + DW - 2 +: 2] = `BODY;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        in_valid = '0;
        @(negedge clk);
        rstn = 1'b1;

        // single packet on input 2
        push_pkt(2, 3);
        drain("single_drain", 20);
        chk("single_cnt", pkt_cnt, 1);

        // contention between inputs 0 and 1
        push_pkt(0, 3);
        push_pkt(1, 3);
        drain("contention_drain", 30);
        chk("contention_cnt", pkt_cnt, 3);

        // fairness: all inputs with two 2-flit packets each
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push_pkt(k, 2);
        drain("fair_drain", 60);
        chk("fair_cnt", pkt_cnt, 11);

        // backpressure mid-packet
        push_pkt(1, 6);
        for (int i = 0; i < 3; i++) step();
        ordy_low = 5;
        drain("bp_drain", 40);

        // protocol error: stray BODY on input 3 while idle
        begin
            logic [DW-1:0] sf;
            sf = $urandom;
            sf[DW-1:DW-2] = `BODY;
            q[3].push_back(sf);
        end
        step();
        step();
        chk("err_set", err, 1);
        push_pkt(1, 3);
        drain("err_drain", 20);
        chk("err_sticky", err, 1);

        // random traffic with backpressure, gaps and occasional stray flits
        ordy_pct = 70;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (q[k].size() < 8 && $urandom_range(0, 99) < 15) begin
                    if ($urandom_range(0, 99) < 3) push_stray(k);
                    else push_pkt(k, $urandom_range(2, 6));
                end
                en[k] = ($urandom_range(0, 99) < 80);
            end
            step();
        end
        for (int k = 0; k < N; k++) en[k] = 1'b1;
        ordy_pct = 100;
        drain("rand_drain", 2000);

        // asynchronous reset in the middle of a packet
        push_pkt(0, 6);
        push_pkt(2, 4);
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_valid", out_valid, 1);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_err", err, 0);
        chk("arst_pkt_cnt", pkt_cnt, 0);
        chk("arst_out_data", out_data, 0);
        for (int k = 0; k < N; k++) q[k].delete();
        in_valid = '0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        push_pkt(2, 3);
        drain("post_rst_drain", 20);
        chk("post_rst_cnt", pkt_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
